// File: rtl/tone_mixer.sv
// tone_mixer: four square-wave voices summed into an unsigned mix, latched at
// a fixed sample rate and also driven out as 1-bit PWM.
// tone_voice is the per-voice counter/phase; tone_mixer instantiates four of
// them and owns the mixer, sample divider and PWM ramp.

// tone_voice: one square-wave voice with a half-period of i_freq clocks.
module tone_voice #(
    parameter int AMP = 63
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] i_freq,
    output logic [7:0] o_level
);
    localparam logic [7:0] LVL = 8'(AMP);

    logic [7:0] r_cnt;
    logic       r_phase;
    logic       w_on;
    logic       w_wrap;

    // '>=' (not '==') lets a shrinking half-period wrap on the very next
    // clock instead of running the counter up to 255 first.
    assign w_on   = (i_freq != 8'd0);
    assign w_wrap = w_on && (r_cnt >= (i_freq - 8'd1));

    // Half-period counter and phase; silence parks the voice at phase 0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt   <= 8'd0;
            r_phase <= 1'b0;
        end else if (!w_on) begin
            r_cnt   <= 8'd0;
            r_phase <= 1'b0;
        end else if (w_wrap) begin
            r_cnt   <= 8'd0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + 8'd1;
        end
    end

    assign o_level = r_phase ? LVL : 8'd0;
endmodule

module tone_mixer #(
    parameter int AMP        = 63,
    parameter int SAMPLE_DIV = 256
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] freq1,
    input  logic [7:0] freq2,
    input  logic [7:0] freq3,
    input  logic [7:0] freq4,
    output logic [3:0] voice_active,
    output logic [9:0] mix,
    output logic [9:0] sample,
    output logic       sample_valid,
    output logic       pwm
);
    localparam int          NUM_VOICES = 4;
    localparam logic [15:0] DIV_LAST   = 16'(SAMPLE_DIV - 1);

    logic [NUM_VOICES-1:0][7:0] w_freq;
    logic [NUM_VOICES-1:0][7:0] w_level;
    logic [NUM_VOICES-1:0]      w_active;
    logic [9:0]                 w_sum;
    logic                       w_strobe;

    logic [3:0]  r_active;
    logic [9:0]  r_mix;
    logic [15:0] r_div;
    logic [9:0]  r_sample;
    logic        r_valid;
    logic [9:0]  r_ramp;
    logic        r_pwm;

    assign w_freq = {freq4, freq3, freq2, freq1};

    generate
        for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
            tone_voice #(.AMP(AMP)) u_voice (
                .clk     (clk),
                .reset_n (reset_n),
                .i_freq  (w_freq[v]),
                .o_level (w_level[v])
            );
            assign w_active[v] = (w_freq[v] != 8'd0);
        end
    endgenerate

    // Sum of voice levels; 4*255 = 1020 always fits in 10 bits.
    always_comb begin
        w_sum = 10'd0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            w_sum = w_sum + {2'b00, w_level[v]};
        end
    end

    assign w_strobe = (r_div == DIV_LAST);

    // Registered voice-active flags and mix.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_active <= 4'd0;
            r_mix    <= 10'd0;
        end else begin
            r_active <= w_active;
            r_mix    <= w_sum;
        end
    end

    // Sample divider: latch mix once every SAMPLE_DIV clocks with a strobe.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_div    <= 16'd0;
            r_sample <= 10'd0;
            r_valid  <= 1'b0;
        end else begin
            r_div   <= w_strobe ? 16'd0 : (r_div + 16'd1);
            r_valid <= w_strobe;
            if (w_strobe) begin
                r_sample <= r_mix;
            end
        end
    end

    // Free-running 10-bit ramp compared against the held sample.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ramp <= 10'd0;
            r_pwm  <= 1'b0;
        end else begin
            r_ramp <= r_ramp + 10'd1;
            r_pwm  <= (r_ramp < r_sample);
        end
    end

    assign voice_active = r_active;
    assign mix          = r_mix;
    assign sample       = r_sample;
    assign sample_valid = r_valid;
    assign pwm          = r_pwm;
endmodule
